// File: rtl/ldtu_ofifo_lanes.sv
// ldtu_ofifo_lanes: circular word buffer feeding NLanes serializer lanes (broadcast or striped).
// Latency: a word written at edge n can reach lane 0 at edge n+1; all outputs are registered.
// Backpressure: none upstream; a write that does not fit is dropped, pulses losing_data and bumps lost_cnt.
// Ports: CLK/RST (async, active-high); write_signal/data_in_32 push; read_signal/lane_mode/handshake
//        control lane updates; DATA32_lanes/valid_lanes lane outputs; count/empty/full/almost_full
//        occupancy; losing_data/lost_cnt drop reporting.
module ldtu_ofifo_lanes #(
  parameter int Nbits_32       = 32,
  parameter int FifoDepth_buff = 16,
  parameter int bits_ptr       = 4,
  parameter int NLanes         = 4,
  parameter int AF_THRESH      = 12,
  parameter logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA,
  parameter logic [Nbits_32-1:0] SYNC_WORD = 32'h5A5A5A5A
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       write_signal,
  input  logic [Nbits_32-1:0]        data_in_32,
  input  logic                       read_signal,
  input  logic                       lane_mode,
  input  logic                       handshake,
  output logic [NLanes*Nbits_32-1:0] DATA32_lanes,
  output logic [NLanes-1:0]          valid_lanes,
  output logic [bits_ptr:0]          count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       losing_data,
  output logic [7:0]                 lost_cnt
);

  localparam logic [bits_ptr:0] DEPTH_C = (bits_ptr+1)'(FifoDepth_buff);
  localparam logic [bits_ptr:0] LANES_C = (bits_ptr+1)'(NLanes);
  localparam logic [bits_ptr:0] AF_C    = (bits_ptr+1)'(AF_THRESH);
  localparam logic [bits_ptr:0] ONE_C   = (bits_ptr+1)'(1);

  logic [Nbits_32-1:0]        mem [FifoDepth_buff];
  logic [bits_ptr-1:0]        wp, rp;
  logic [bits_ptr:0]          pop_n;
  logic [bits_ptr:0]          count_next;
  logic                       accept;
  logic                       lane_upd;
  logic [NLanes*Nbits_32-1:0] lanes_next;
  logic [NLanes-1:0]          valid_next;

  // Words popped this cycle; handshake suppresses any pop.
  always_comb begin
    pop_n = '0;
    if (read_signal && !handshake) begin
      if (lane_mode) pop_n = (count > LANES_C) ? LANES_C : count;
      else           pop_n = (count != '0) ? ONE_C : '0;
    end
  end

  // A slot freed by a same-cycle pop can take the incoming word.
  assign accept     = write_signal && ((count - pop_n) < DEPTH_C);
  assign count_next = count - pop_n + {{bits_ptr{1'b0}}, accept};

  // Lane contents always come from pre-edge memory; index wraps naturally in bits_ptr bits.
  always_comb begin
    lane_upd   = 1'b0;
    lanes_next = DATA32_lanes;
    valid_next = valid_lanes;
    if (handshake) begin
      lane_upd = 1'b1;
      for (int k = 0; k < NLanes; k++) begin
        lanes_next[k*Nbits_32 +: Nbits_32] = SYNC_WORD;
        valid_next[k]                      = 1'b0;
      end
    end else if (read_signal) begin
      lane_upd = 1'b1;
      for (int k = 0; k < NLanes; k++) begin
        if (!lane_mode) begin
          lanes_next[k*Nbits_32 +: Nbits_32] = (count != '0) ? mem[rp] : IDLE_WORD;
          valid_next[k]                      = (count != '0);
        end else if ((bits_ptr+1)'(k) < pop_n) begin
          lanes_next[k*Nbits_32 +: Nbits_32] = mem[rp + bits_ptr'(k)];
          valid_next[k]                      = 1'b1;
        end else begin
          lanes_next[k*Nbits_32 +: Nbits_32] = IDLE_WORD;
          valid_next[k]                      = 1'b0;
        end
      end
    end
  end

  // Storage array needs no reset: count/pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (accept) mem[wp] <= data_in_32;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      losing_data  <= 1'b0;
      lost_cnt     <= '0;
      DATA32_lanes <= {NLanes{IDLE_WORD}};
      valid_lanes  <= '0;
    end else begin
      wp          <= wp + {{(bits_ptr-1){1'b0}}, accept};
      rp          <= rp + pop_n[bits_ptr-1:0];
      count       <= count_next;
      empty       <= (count_next == '0);
      full        <= (count_next == DEPTH_C);
      almost_full <= (count_next >= AF_C);
      losing_data <= write_signal && !accept;
      if (write_signal && !accept && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      if (lane_upd) begin
        DATA32_lanes <= lanes_next;
        valid_lanes  <= valid_next;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_ofifo_lanes.sv
// tb_ldtu_ofifo_lanes: directed checks of ldtu_ofifo_lanes with the default 16-deep, 4-lane build.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// A table of hand-computed vectors covers the basic modes; queue-based sequences cover full/wrap/reset.
module tb_ldtu_ofifo_lanes;
  localparam logic [31:0] IDLE = 32'hEAAAAAAA;
  localparam logic [31:0] SYNC = 32'h5A5A5A5A;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         write_signal = 1'b0;
  logic [31:0]  data_in_32 = '0;
  logic         read_signal = 1'b0;
  logic         lane_mode = 1'b0;
  logic         handshake = 1'b0;
  logic [127:0] DATA32_lanes;
  logic [3:0]   valid_lanes;
  logic [4:0]   count;
  logic         empty, full, almost_full, losing_data;
  logic [7:0]   lost_cnt;

  int ncmp = 0;
  int nfail = 0;

  ldtu_ofifo_lanes dut (
    .CLK(CLK), .RST(RST), .write_signal(write_signal), .data_in_32(data_in_32),
    .read_signal(read_signal), .lane_mode(lane_mode), .handshake(handshake),
    .DATA32_lanes(DATA32_lanes), .valid_lanes(valid_lanes), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .losing_data(losing_data), .lost_cnt(lost_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         wr;
    logic [31:0]  din;
    logic         rd;
    logic         mode;
    logic         hs;
    logic [127:0] lanes;
    logic [3:0]   vld;
    logic [4:0]   cnt;
    logic         emp;
  } vec_t;

  vec_t tbl [20];

  // Reference state: queue of stored words plus expected registered outputs.
  logic [31:0]  q [$];
  logic [127:0] m_lanes;
  logic [3:0]   m_vld;
  logic         m_lose;
  logic [7:0]   m_lost;

  function automatic logic [127:0] lanes4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] din, input logic rd,
                              input logic mode, input logic hs, input logic [127:0] lanes,
                              input logic [3:0] vld, input logic [4:0] cnt, input logic emp);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.mode = mode; v.hs = hs;
    v.lanes = lanes; v.vld = vld; v.cnt = cnt; v.emp = emp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lanes = {4{IDLE}};
    m_vld   = '0;
    m_lose  = 1'b0;
    m_lost  = '0;
  endtask

  task automatic model_step(input logic wr, input logic [31:0] din, input logic rd,
                            input logic mode, input logic hs);
    int sz;
    int p;
    logic acc;
    sz = q.size();
    p  = 0;
    if (rd && !hs) p = mode ? ((sz < 4) ? sz : 4) : ((sz < 1) ? sz : 1);
    if (hs) begin
      m_lanes = {4{SYNC}};
      m_vld   = '0;
    end else if (rd) begin
      for (int k = 0; k < 4; k++) begin
        if (!mode && sz > 0) begin
          m_lanes[k*32 +: 32] = q[0];
          m_vld[k]            = 1'b1;
        end else if (mode && k < p) begin
          m_lanes[k*32 +: 32] = q[k];
          m_vld[k]            = 1'b1;
        end else begin
          m_lanes[k*32 +: 32] = IDLE;
          m_vld[k]            = 1'b0;
        end
      end
    end
    for (int i = 0; i < p; i++) void'(q.pop_front());
    acc = wr && ((sz - p) < 16);
    if (acc) q.push_back(din);
    m_lose = wr && !acc;
    if (m_lose && m_lost != 8'hFF) m_lost = m_lost + 8'd1;
  endtask

  // One clock: drive at the falling edge, advance through the rising edge, sample at the next falling edge.
  task automatic cyc(input logic wr, input logic [31:0] din, input logic rd,
                     input logic mode, input logic hs);
    write_signal = wr;
    data_in_32   = din;
    read_signal  = rd;
    lane_mode    = mode;
    handshake    = hs;
    model_step(wr, din, rd, mode, hs);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".lanes"}, DATA32_lanes, m_lanes);
    chk({tag, ".valid"}, 128'(valid_lanes), 128'(m_vld));
    chk({tag, ".count"}, 128'(count), 128'(sz));
    chk({tag, ".flags"}, 128'({empty, full, almost_full}),
        128'({sz == 0, sz == 16, sz >= 12}));
    chk({tag, ".losing"}, 128'(losing_data), 128'(m_lose));
    chk({tag, ".lost_cnt"}, 128'(lost_cnt), 128'(m_lost));
  endtask

  initial begin
    // Hand-computed table: broadcast order, striped partial, hold, handshake, same-cycle write/read.
    tbl[0] = mk(1, 32'h1, 0, 0, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0, 5'd1, 0);
    tbl[1] = mk(1, 32'h2, 0, 0, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0, 5'd2, 0);
    tbl[2] = mk(1, 32'h3, 0, 0, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0, 5'd3, 0);
    tbl[3] = mk(0, 32'h0, 1, 0, 0, lanes4(32'h1, 32'h1, 32'h1, 32'h1), 4'hF, 5'd2, 0);
    tbl[4] = mk(0, 32'h0, 1, 0, 0, lanes4(32'h2, 32'h2, 32'h2, 32'h2), 4'hF, 5'd1, 0);
    tbl[5] = mk(0, 32'h0, 1, 0, 0, lanes4(32'h3, 32'h3, 32'h3, 32'h3), 4'hF, 5'd0, 1);
    tbl[6] = mk(0, 32'h0, 1, 0, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0, 5'd0, 1);
    tbl[7] = mk(0, 32'h0, 0, 0, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0, 5'd0, 1);
    for (int i = 0; i < 6; i++)
      tbl[8+i] = mk(1, 32'hA0 + 32'(i), 0, 1, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0,
                    5'(i + 1), 0);
    tbl[14] = mk(0, 32'h0, 1, 1, 0, lanes4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 4'hF, 5'd2, 0);
    tbl[15] = mk(0, 32'h0, 1, 1, 0, lanes4(32'hA4, 32'hA5, IDLE, IDLE), 4'h3, 5'd0, 1);
    tbl[16] = mk(0, 32'h0, 0, 1, 0, lanes4(32'hA4, 32'hA5, IDLE, IDLE), 4'h3, 5'd0, 1);
    tbl[17] = mk(0, 32'h0, 1, 1, 1, lanes4(SYNC, SYNC, SYNC, SYNC), 4'h0, 5'd0, 1);
    tbl[18] = mk(1, 32'hB0, 1, 1, 0, lanes4(IDLE, IDLE, IDLE, IDLE), 4'h0, 5'd1, 0);
    tbl[19] = mk(0, 32'h0, 1, 0, 0, lanes4(32'hB0, 32'hB0, 32'hB0, 32'hB0), 4'hF, 5'd0, 1);

    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Reset then idle.
    chk("rst.lanes", DATA32_lanes, {4{IDLE}});
    chk("rst.valid", 128'(valid_lanes), 128'(4'h0));
    chk("rst.count", 128'(count), 128'(0));
    chk("rst.empty", 128'(empty), 128'(1));
    chk("rst.full_af", 128'({full, almost_full}), 128'(0));
    chk("rst.lost", 128'({losing_data, lost_cnt}), 128'(0));

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].mode, tbl[i].hs);
      chk($sformatf("vec%0d.lanes", i), DATA32_lanes, tbl[i].lanes);
      chk($sformatf("vec%0d.valid", i), 128'(valid_lanes), 128'(tbl[i].vld));
      chk($sformatf("vec%0d.count", i), 128'(count), 128'(tbl[i].cnt));
      chk($sformatf("vec%0d.empty", i), 128'(empty), 128'(tbl[i].emp));
    end

    // Full and overflow: 18 writes, two dropped.
    for (int i = 0; i < 18; i++) begin
      cyc(1, 32'hC00 + 32'(i), 0, 0, 0);
      check_model($sformatf("fill%0d", i));
    end
    chk("ovf.lost_cnt", 128'(lost_cnt), 128'(2));
    chk("ovf.full", 128'(full), 128'(1));
    cyc(0, 0, 0, 0, 0);
    check_model("ovf.quiet");
    cyc(1, 32'hCFF, 1, 0, 0);
    check_model("full.wr_rd");
    chk("full.wr_rd.count", 128'(count), 128'(16));
    chk("full.wr_rd.lane0", 128'(DATA32_lanes[31:0]), 128'(32'hC00));
    for (int i = 0; i < 6 && q.size() > 0; i++) begin
      cyc(0, 0, 1, 1, 0);
      check_model($sformatf("drain%0d", i));
    end

    // Wrap: three writes then one striped read, repeated, so reads straddle index 15 -> 0.
    for (int i = 0; i < 53; i++) begin
      if (i % 4 == 3) cyc(0, 0, 1, 1, 0);
      else            cyc(1, 32'hD00 + 32'(i), 0, 1, 0);
      check_model($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      cyc(0, 0, 1, 1, 0);
      check_model($sformatf("wdrain%0d", i));
    end

    // Handshake overrides a read and pops nothing.
    for (int i = 0; i < 3; i++) cyc(1, 32'hE10 + 32'(i), 0, 1, 0);
    cyc(0, 0, 1, 1, 1);
    check_model("hs");
    chk("hs.count", 128'(count), 128'(3));
    cyc(0, 0, 1, 1, 0);
    check_model("hs.after");
    chk("hs.after.lane0", 128'(DATA32_lanes[31:0]), 128'(32'hE10));

    // Saturation of lost_cnt.
    for (int i = 0; i < 16 && q.size() < 16; i++) cyc(1, 32'hF00 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 32'hBAD, 0, 0, 0);
      if (i % 50 == 0 || i > 295) check_model($sformatf("sat%0d", i));
    end
    chk("sat.lost_cnt", 128'(lost_cnt), 128'(255));

    // Mid-run asynchronous reset.
    #2 RST = 1'b1;
    #1;
    chk("arst.lanes", DATA32_lanes, {4{IDLE}});
    chk("arst.count", 128'(count), 128'(0));
    chk("arst.flags", 128'({empty, full, almost_full, losing_data}), 128'(4'b1000));
    chk("arst.lost", 128'(lost_cnt), 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    cyc(1, 32'h1234_5678, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_model("post_rst");
    chk("post_rst.lanes", DATA32_lanes, {4{32'h1234_5678}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
